// File: rtl/amba3_apb_mem_slave.sv
// AMBA 3 APB completer backed by a word-addressed register memory.
// Supports runtime access-phase wait states and PSLVERR on unaligned/out-of-range addresses.
module amba3_apb_mem_slave #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned WAIT_W    = 4
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDR_SIZE-1:0] paddr,
  input  logic [DATA_SIZE-1:0] pwdata,
  output logic [DATA_SIZE-1:0] prdata,
  output logic                 pready,
  output logic                 pslverr,
  input  logic [WAIT_W-1:0]    wait_cfg
);

  localparam int unsigned DATA_BASE = $clog2(DATA_SIZE / 8);
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'((64'd1 << DATA_BASE) - 64'd1);
  localparam logic [ADDR_SIZE-1:0] DEPTH_A    = ADDR_SIZE'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic                 wr_q, wr_d;
  logic                 err_q, err_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DATA_SIZE-1:0] prdata_q, prdata_d;
  logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];
  logic                 mem_we;

  logic                 setup, setup_err;
  logic [IDX_W-1:0]     setup_idx;
  logic                 ld_wr, ld_err;
  logic [IDX_W-1:0]     ld_idx;

  assign setup     = psel & ~penable;
  assign setup_err = (|(paddr & ALIGN_MASK)) | ((paddr >> DATA_BASE) >= DEPTH_A);
  assign setup_idx = paddr[DATA_BASE +: IDX_W];

  // Response is loaded either straight from the setup bus (no waits) or from the setup latch.
  assign ld_wr  = (state_q == S_IDLE) ? pwrite    : wr_q;
  assign ld_err = (state_q == S_IDLE) ? setup_err : err_q;
  assign ld_idx = (state_q == S_IDLE) ? setup_idx : idx_q;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          wr_d    = pwrite;
          err_d   = setup_err;
          idx_d   = setup_idx;
          wdata_d = pwdata;
          if (wait_cfg == '0) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = ld_err;
            prdata_d  = (!ld_wr && !ld_err) ? mem_q[ld_idx] : '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_cfg;
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d   = S_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (penable) begin
          if (cnt_q == WAIT_W'(1)) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = ld_err;
            prdata_d  = (!ld_wr && !ld_err) ? mem_q[ld_idx] : '0;
          end else begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
        end
      end
      S_RESP: begin
        if (!psel || penable) begin
          mem_we    = psel & wr_q & ~err_q;
          state_d   = S_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (mem_we) begin
        mem_q[idx_q] <= wdata_q;
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_amba3_apb_mem_slave.sv
// Directed and scoreboard-driven bench for the APB memory completer.
module tb_amba3_apb_mem_slave;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic [3:0]  wait_cfg;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] sb [64];
  int unsigned perm [64];

  always #5 pclk = ~pclk;

  amba3_apb_mem_slave #(
    .ADDR_SIZE(32),
    .DATA_SIZE(32),
    .MEM_DEPTH(64),
    .WAIT_W   (4)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .wait_cfg(wait_cfg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transfer starting in the current cycle (called #1 after an edge); access-phase
  // bus values are scrambled so only the setup-phase values may matter.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] nw, input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
    int unsigned cyc;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; wait_cfg = nw;
    @(posedge pclk); #1;
    penable = 1'b1; pwrite = ~wr; paddr = ~addr; pwdata = ~data; wait_cfg = ~nw;
    cyc = 2;
    while (!pready && cyc < 40) begin
      @(posedge pclk); #1;
      cyc++;
    end
    chk({tag, " len"}, 64'(cyc), 64'(2 + nw));
    chk({tag, " prdata"}, 64'(prdata), 64'(exp_rd));
    chk({tag, " pslverr"}, 64'(pslverr), 64'(exp_err));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    chk({tag, " pready_clr"}, 64'(pready), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic quiet;
    int unsigned j, t, idx;
    logic [31:0] d;
    logic [3:0]  w;

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; wait_cfg = '0;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset pready", 64'(pready), 64'd0);
    chk("reset pslverr", 64'(pslverr), 64'd0);
    chk("reset prdata", 64'(prdata), 64'd0);
    preset = 1'b0;
    @(posedge pclk); #1;

    // Zero-wait write then read
    xfer(1'b1, 32'h0040, 32'h8000_3333, 4'd0, 32'h0, 1'b0, "t1 wr");
    xfer(1'b0, 32'h0040, 32'h0,         4'd0, 32'h8000_3333, 1'b0, "t1 rd");

    // Three wait states
    xfer(1'b1, 32'h0084, 32'h0440_0011, 4'd3, 32'h0, 1'b0, "t2 wr");
    xfer(1'b0, 32'h0084, 32'h0,         4'd3, 32'h0440_0011, 1'b0, "t2 rd");

    // Error responses; both faulty writes alias idx 0, which must stay 0
    xfer(1'b1, 32'h0102, 32'h0000_DEAD, 4'd0, 32'h0, 1'b1, "t3 wr unaligned");
    xfer(1'b1, 32'h0800, 32'h0000_BEEF, 4'd1, 32'h0, 1'b1, "t3 wr range");
    xfer(1'b0, 32'h0100, 32'h0,         4'd0, 32'h0, 1'b1, "t3 rd 0x100");
    xfer(1'b0, 32'h0800, 32'h0,         4'd2, 32'h0, 1'b1, "t3 rd 0x800");
    xfer(1'b0, 32'h0000, 32'h0,         4'd0, 32'h0, 1'b0, "t3 rd idx0");
    xfer(1'b0, 32'h00FC, 32'h0,         4'd0, 32'h0, 1'b0, "t3 rd idx63");

    // Back-to-back, no idle cycles
    xfer(1'b1, 32'h0040, 32'h1234_5678, 4'd0, 32'h0, 1'b0, "t4 wr a");
    xfer(1'b1, 32'h0018, 32'h2244_6688, 4'd0, 32'h0, 1'b0, "t4 wr b");
    xfer(1'b0, 32'h0040, 32'h0,         4'd0, 32'h1234_5678, 1'b0, "t4 rd a");
    xfer(1'b0, 32'h0018, 32'h0,         4'd0, 32'h2244_6688, 1'b0, "t4 rd b");
    xfer(1'b1, 32'h0018, 32'h55AA_55AA, 4'd0, 32'h0, 1'b0, "t4 wr b2");
    xfer(1'b0, 32'h0018, 32'h0,         4'd0, 32'h55AA_55AA, 1'b0, "t4 rd b2");

    // Abort by dropping psel in the second wait cycle
    xfer(1'b1, 32'h0010, 32'h1111_1111, 4'd0, 32'h0, 1'b0, "t5 wr old");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0010;
    pwdata = 32'hA5A5_A5A5; wait_cfg = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    chk("t5 abort pready pre", 64'(pready), 64'd0);
    psel = 1'b0; penable = 1'b0;
    quiet = 1'b1;
    repeat (8) begin
      @(posedge pclk); #1;
      if (pready || pslverr || prdata != 0) quiet = 1'b0;
    end
    chk("t5 abort quiet", 64'(quiet), 64'd1);
    xfer(1'b0, 32'h0010, 32'h0, 4'd0, 32'h1111_1111, 1'b0, "t5 rd old");

    // Reset in the middle of a waited write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0020;
    pwdata = 32'hA5A5_A5A5; wait_cfg = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    chk("t5 rst pready", 64'(pready), 64'd0);
    chk("t5 rst pslverr", 64'(pslverr), 64'd0);
    chk("t5 rst prdata", 64'(prdata), 64'd0);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    for (int i = 0; i < 64; i++) begin
      xfer(1'b0, 32'(i * 4), 32'h0, 4'd0, 32'h0, 1'b0, "t5 rst rd");
    end

    // Random writes against a scoreboard, then a shuffled full read-back
    for (int i = 0; i < 64; i++) begin
      sb[i] = '0;
      perm[i] = i;
    end
    for (int i = 0; i < 1000; i++) begin
      idx = $urandom_range(0, 63);
      d   = $urandom;
      w   = 4'($urandom_range(0, 15));
      xfer(1'b1, 32'(idx * 4), d, w, 32'h0, 1'b0, "t6 wr");
      sb[idx] = d;
    end
    for (int i = 63; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 64; i++) begin
      w = 4'($urandom_range(0, 15));
      xfer(1'b0, 32'(perm[i] * 4), 32'h0, w, sb[perm[i]], 1'b0, "t6 rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
